// File: rtl/part08_decoder.sv
// ---------------------------------------------------------------------------
// part08_decoder
//
// Receive-side decoder for the registered a/b priority encoder. Every clock it
// samples the encoder's y/z code pair, works out which input was last active,
// counts a-runs and b-runs and raises a sticky flag on illegal codes.
// All outputs are registered (one cycle after the sampled inputs).
//
// Parameters:
//   CNT_W    width of each run counter; counters saturate at all-ones
//
// Ports:
//   clk      rising-edge clock shared with the encoder
//   rst      synchronous, active-high reset
//   y_in     encoder y code; y_in[1]=1 means "a asserted", y_in[0] ignored
//   z_in     encoder z code; 01 = last event a, 10 = last event b
//   a_out    a was active on the sampled cycle
//   b_out    last decoded event is b and a is not active
//   a_cnt    number of a-runs (entries into A_ACT)
//   b_cnt    number of b-runs (entries into B_LAST)
//   err      sticky illegal-code flag
//   state_o  current FSM state (00 IDLE, 01 A_ACT, 10 B_LAST)
// ---------------------------------------------------------------------------
module part08_decoder #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       y_in,
  input  logic [1:0]       z_in,
  output logic             a_out,
  output logic             b_out,
  output logic [CNT_W-1:0] a_cnt,
  output logic [CNT_W-1:0] b_cnt,
  output logic             err,
  output logic [1:0]       state_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    A_ACT  = 2'b01,
    B_LAST = 2'b10
  } state_t;

  state_t           state_q, state_d;
  logic             a_out_q, a_out_d;
  logic             b_out_q, b_out_d;
  logic [CNT_W-1:0] a_cnt_q, a_cnt_d;
  logic [CNT_W-1:0] b_cnt_q, b_cnt_d;
  logic             err_q, err_d;

  logic a_hit;
  logic z_is_a;
  logic z_is_b;
  logic a_enter;
  logic b_enter;

  // y_in[0] carries no information for this decoder.
  logic unused_y0;
  assign unused_y0 = y_in[0];

  assign a_hit  = y_in[1];
  assign z_is_a = (z_in == 2'b01);
  assign z_is_b = (z_in == 2'b10);

  // Next-state, error and run-entry decode.
  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    a_enter = 1'b0;
    b_enter = 1'b0;

    case (state_q)
      IDLE: begin
        // z is uninitialised before the encoder's first event, so no code
        // checking happens here.
        if (a_hit) begin
          state_d = A_ACT;
          a_enter = 1'b1;
        end else if (z_is_b) begin
          state_d = B_LAST;
          b_enter = 1'b1;
        end
      end

      A_ACT: begin
        if (a_hit) begin
          if (!z_is_a) err_d = 1'b1;
        end else if (z_is_b) begin
          state_d = B_LAST;
          b_enter = 1'b1;
        end else if (!z_is_a) begin
          err_d = 1'b1;
        end
      end

      B_LAST: begin
        if (a_hit) begin
          state_d = A_ACT;
          a_enter = 1'b1;
          if (!z_is_a) err_d = 1'b1;
        end else if (!z_is_b) begin
          // Repeated b and idle-after-b both show z=10; anything else is bad.
          err_d = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Saturating run counters and registered event outputs.
  always_comb begin
    a_cnt_d = a_cnt_q;
    b_cnt_d = b_cnt_q;
    if (a_enter && (a_cnt_q != {CNT_W{1'b1}})) a_cnt_d = a_cnt_q + CNT_W'(1);
    if (b_enter && (b_cnt_q != {CNT_W{1'b1}})) b_cnt_d = b_cnt_q + CNT_W'(1);

    a_out_d = a_hit;
    b_out_d = (state_d == B_LAST) && !a_hit;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_out_q <= 1'b0;
      b_out_q <= 1'b0;
      a_cnt_q <= '0;
      b_cnt_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_out_q <= a_out_d;
      b_out_q <= b_out_d;
      a_cnt_q <= a_cnt_d;
      b_cnt_q <= b_cnt_d;
      err_q   <= err_d;
    end
  end

  assign a_out   = a_out_q;
  assign b_out   = b_out_q;
  assign a_cnt   = a_cnt_q;
  assign b_cnt   = b_cnt_q;
  assign err     = err_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_part08_decoder.sv
// ---------------------------------------------------------------------------
// tb_part08_decoder
//
// Directed bench for part08_decoder. Two instances share the same stimulus:
// dut (CNT_W=8) is checked on every output, dut2 (CNT_W=2) is checked on its
// counters so saturation can be reached in a few runs. Each step pushes its
// expected result to a scoreboard queue when inputs are driven; the entry is
// popped and compared once the registered outputs are visible.
// ---------------------------------------------------------------------------
module tb_part08_decoder;

  logic       clk;
  logic       rst;
  logic [1:0] y_in;
  logic [1:0] z_in;

  logic       a_out, b_out, err;
  logic [7:0] a_cnt, b_cnt;
  logic [1:0] state_o;

  logic       a_out2, b_out2, err2;
  logic [1:0] a_cnt2, b_cnt2;
  logic [1:0] state2;

  typedef struct {
    logic       a_out;
    logic       b_out;
    logic [7:0] a_cnt;
    logic [7:0] b_cnt;
    logic       err;
    logic [1:0] state;
    logic [1:0] a_cnt2;
    logic [1:0] b_cnt2;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   step_no = 0;

  part08_decoder #(.CNT_W(8)) dut (
    .clk(clk), .rst(rst), .y_in(y_in), .z_in(z_in),
    .a_out(a_out), .b_out(b_out), .a_cnt(a_cnt), .b_cnt(b_cnt),
    .err(err), .state_o(state_o)
  );

  part08_decoder #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .y_in(y_in), .z_in(z_in),
    .a_out(a_out2), .b_out(b_out2), .a_cnt(a_cnt2), .b_cnt(b_cnt2),
    .err(err2), .state_o(state2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [1:0] sat2(input int v);
    return (v > 3) ? 2'd3 : 2'(v);
  endfunction

  // One clock: drive inputs, record expectation, compare after the edge.
  task automatic step(input logic r, input logic [1:0] y, input logic [1:0] z,
                      input logic ea, input logic eb, input int eac, input int ebc,
                      input logic ee, input logic [1:0] es);
    exp_t e;
    exp_t g;
    e.a_out  = ea;
    e.b_out  = eb;
    e.a_cnt  = 8'(eac);
    e.b_cnt  = 8'(ebc);
    e.err    = ee;
    e.state  = es;
    e.a_cnt2 = sat2(eac);
    e.b_cnt2 = sat2(ebc);
    @(negedge clk);
    rst  = r;
    y_in = y;
    z_in = z;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    step_no++;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL step%0d scoreboard empty", step_no);
    end else begin
      g = exp_q.pop_front();
      checks++;
      assert (a_out === g.a_out) else begin
        errors++; $error("FAIL step%0d a_out got=%b exp=%b", step_no, a_out, g.a_out);
      end
      checks++;
      assert (b_out === g.b_out) else begin
        errors++; $error("FAIL step%0d b_out got=%b exp=%b", step_no, b_out, g.b_out);
      end
      checks++;
      assert (a_cnt === g.a_cnt) else begin
        errors++; $error("FAIL step%0d a_cnt got=%0d exp=%0d", step_no, a_cnt, g.a_cnt);
      end
      checks++;
      assert (b_cnt === g.b_cnt) else begin
        errors++; $error("FAIL step%0d b_cnt got=%0d exp=%0d", step_no, b_cnt, g.b_cnt);
      end
      checks++;
      assert (err === g.err) else begin
        errors++; $error("FAIL step%0d err got=%b exp=%b", step_no, err, g.err);
      end
      checks++;
      assert (state_o === g.state) else begin
        errors++; $error("FAIL step%0d state_o got=%b exp=%b", step_no, state_o, g.state);
      end
      checks++;
      assert (a_cnt2 === g.a_cnt2) else begin
        errors++; $error("FAIL step%0d sat_a_cnt got=%0d exp=%0d", step_no, a_cnt2, g.a_cnt2);
      end
      checks++;
      assert (b_cnt2 === g.b_cnt2) else begin
        errors++; $error("FAIL step%0d sat_b_cnt got=%0d exp=%0d", step_no, b_cnt2, g.b_cnt2);
      end
    end
    $display("step%0d rst=%b y=%b z=%b -> a_out=%b b_out=%b a_cnt=%0d b_cnt=%0d err=%b state=%b sat=%0d/%0d",
             step_no, r, y, z, a_out, b_out, a_cnt, b_cnt, err, state_o, a_cnt2, b_cnt2);
  endtask

  initial begin
    rst  = 1'b1;
    y_in = 2'b00;
    z_in = 2'b00;

    // Reset held two clocks with an active a code: nothing may leak through.
    step(1, 2'b11, 2'b01, 0, 0, 0, 0, 0, 2'b00);
    step(1, 2'b11, 2'b01, 0, 0, 0, 0, 0, 2'b00);
    step(0, 2'b11, 2'b01, 1, 0, 1, 0, 0, 2'b01);

    // Run counting: a,a,a,idle,b,b,idle-after-b,a.
    step(1, 2'b00, 2'b00, 0, 0, 0, 0, 0, 2'b00);
    step(0, 2'b10, 2'b01, 1, 0, 1, 0, 0, 2'b01);
    step(0, 2'b10, 2'b01, 1, 0, 1, 0, 0, 2'b01);
    step(0, 2'b10, 2'b01, 1, 0, 1, 0, 0, 2'b01);
    step(0, 2'b00, 2'b01, 0, 0, 1, 0, 0, 2'b01);
    step(0, 2'b00, 2'b10, 0, 1, 1, 1, 0, 2'b10);
    step(0, 2'b00, 2'b10, 0, 1, 1, 1, 0, 2'b10);
    step(0, 2'b00, 2'b10, 0, 1, 1, 1, 0, 2'b10);
    step(0, 2'b10, 2'b01, 1, 0, 2, 1, 0, 2'b01);

    // IDLE tolerates uninitialised z codes (00/11) and ignores y_in[0].
    step(1, 2'b00, 2'b00, 0, 0, 0, 0, 0, 2'b00);
    step(0, 2'b01, 2'b00, 0, 0, 0, 0, 0, 2'b00);
    step(0, 2'b01, 2'b11, 0, 0, 0, 0, 0, 2'b00);
    step(0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 2'b00);
    step(0, 2'b01, 2'b11, 0, 0, 0, 0, 0, 2'b00);
    step(0, 2'b00, 2'b11, 0, 0, 0, 0, 0, 2'b00);
    step(0, 2'b00, 2'b10, 0, 1, 0, 1, 0, 2'b10);

    // Illegal code from A_ACT sets a sticky err; FSM holds.
    step(0, 2'b10, 2'b01, 1, 0, 1, 1, 0, 2'b01);
    step(0, 2'b00, 2'b11, 0, 0, 1, 1, 1, 2'b01);
    step(0, 2'b00, 2'b01, 0, 0, 1, 1, 1, 2'b01);
    step(0, 2'b10, 2'b01, 1, 0, 1, 1, 1, 2'b01);
    step(0, 2'b00, 2'b10, 0, 1, 1, 2, 1, 2'b10);

    // a_hit with bad z: tolerated in IDLE, flagged in A_ACT but a still wins.
    step(1, 2'b00, 2'b00, 0, 0, 0, 0, 0, 2'b00);
    step(0, 2'b10, 2'b00, 1, 0, 1, 0, 0, 2'b01);
    step(0, 2'b10, 2'b10, 1, 0, 1, 0, 1, 2'b01);

    // Saturation: five alternating a/b runs; the CNT_W=2 copy stops at 3.
    step(1, 2'b00, 2'b00, 0, 0, 0, 0, 0, 2'b00);
    for (int i = 1; i <= 5; i++) begin
      step(0, 2'b10, 2'b01, 1, 0, i, i - 1, 0, 2'b01);
      step(0, 2'b00, 2'b10, 0, 1, i, i, 0, 2'b10);
    end

    // Reset mid-run in B_LAST coinciding with a_hit: reset wins.
    step(1, 2'b00, 2'b00, 0, 0, 0, 0, 0, 2'b00);
    step(0, 2'b00, 2'b10, 0, 1, 0, 1, 0, 2'b10);
    step(0, 2'b10, 2'b01, 1, 0, 1, 1, 0, 2'b01);
    step(0, 2'b00, 2'b10, 0, 1, 1, 2, 0, 2'b10);
    step(1, 2'b10, 2'b01, 0, 0, 0, 0, 0, 2'b00);
    step(0, 2'b00, 2'b10, 0, 1, 0, 1, 0, 2'b10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
